// File: rtl/aes_v2_pkg.sv
// aes_v2_pkg: shared constants, FSM state type and GF(2^8) helper functions
// for the v2 lightweight AES datapath.
//   - GF_RED      : GF(2^8) reduction constant (x^8 = x^4 + x^3 + x + 1)
//   - AFF_C       : forward affine constant
//   - INV_AFF_C   : inverse affine constant
//   - AFF_ROWS    : forward affine matrix, row i at bits [8i +: 8]
//   - INV_AFF_ROWS: inverse affine matrix, row i at bits [8i +: 8]
//   - fsm_t       : byte-serial sequencing states ST_B0..ST_B3
package aes_v2_pkg;

  localparam logic [7:0]  GF_RED       = 8'h1B;
  localparam logic [7:0]  AFF_C        = 8'h63;
  localparam logic [7:0]  INV_AFF_C    = 8'h05;
  // Row i is 8'hF1 rotated left by i (bits i, i+4..i+7 mod 8).
  localparam logic [63:0] AFF_ROWS     = 64'hF87C3E1F_8FC7E3F1;
  // Row i is 8'hA4 rotated left by i (bits i+2, i+5, i+7 mod 8).
  localparam logic [63:0] INV_AFF_ROWS = 64'h5229944A_259249A4;

  typedef enum logic [1:0] {
    ST_B0 = 2'd0,
    ST_B1 = 2'd1,
    ST_B2 = 2'd2,
    ST_B3 = 2'd3
  } fsm_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^(2+4+...+128); maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(a & AFF_ROWS[i*8 +: 8]);
    return r ^ AFF_C;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(a & INV_AFF_ROWS[i*8 +: 8]);
    return r ^ INV_AFF_C;
  endfunction

endpackage

// File: rtl/aes_v2_sbox.sv
// aes_v2_sbox: combinational AES forward/inverse S-box.
//   din  - input byte
//   enc  - 1 = forward S-box, 0 = inverse S-box
//   dout - substituted byte
module aes_v2_sbox
  import aes_v2_pkg::*;
(
  input  logic [7:0] din,
  input  logic       enc,
  output logic [7:0] dout
);

  // Forward: inverse then affine; inverse: inverse-affine then inverse.
  always_comb begin
    dout = 8'h00;
    if (enc) begin
      dout = affine(gf_inv(din));
    end else begin
      dout = gf_inv(inv_affine(din));
    end
  end

endmodule

// File: rtl/aes_v2_sub_size.sv
// aes_v2_sub_size: byte-serial AES SubBytes unit, one shared S-box.
//   g_clk   - clock (rising edge)
//   g_reset - asynchronous active-high reset
//   valid   - operands valid, held until ready
//   rs1     - bytes 0..1 in [15:0]
//   rs2     - bytes 2..3 in [31:16]
//   enc     - 1 = forward S-box, 0 = inverse
//   ready   - single-cycle result strobe (fsm in last state and valid)
//   rd      - {S(rs2[31:24]), S(rs2[23:16]), S(rs1[15:8]), S(rs1[7:0])}
module aes_v2_sub_size
  import aes_v2_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] rd
);

  fsm_t       fsm_r;
  fsm_t       fsm_nxt_s;
  logic [7:0] b_0_r;
  logic [7:0] b_1_r;
  logic [7:0] b_2_r;
  logic [7:0] s_in_s;
  logic [7:0] s_out_s;
  logic       unused_s;

  // Operand bytes outside the packed form are intentionally ignored.
  assign unused_s = ^{rs1[31:16], rs2[15:0]};

  // Operand byte selection for the shared S-box.
  always_comb begin
    s_in_s = 8'h00;
    case (fsm_r)
      ST_B0:   s_in_s = rs1[7:0];
      ST_B1:   s_in_s = rs1[15:8];
      ST_B2:   s_in_s = rs2[23:16];
      ST_B3:   s_in_s = rs2[31:24];
      default: s_in_s = 8'h00;
    endcase
  end

  aes_v2_sbox u_sbox (
    .din  (s_in_s),
    .enc  (enc),
    .dout (s_out_s)
  );

  // Next-state: advance while valid, abandon on a drop, always wrap after the last byte.
  always_comb begin
    fsm_nxt_s = ST_B0;
    case (fsm_r)
      ST_B0:   fsm_nxt_s = valid ? ST_B1 : ST_B0;
      ST_B1:   fsm_nxt_s = valid ? ST_B2 : ST_B0;
      ST_B2:   fsm_nxt_s = valid ? ST_B3 : ST_B0;
      ST_B3:   fsm_nxt_s = ST_B0;
      default: fsm_nxt_s = ST_B0;
    endcase
  end

  // State and partial-result byte registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      fsm_r <= ST_B0;
      b_0_r <= 8'h00;
      b_1_r <= 8'h00;
      b_2_r <= 8'h00;
    end else begin
      fsm_r <= fsm_nxt_s;
      if (valid) begin
        case (fsm_r)
          ST_B0:   b_0_r <= s_out_s;
          ST_B1:   b_1_r <= s_out_s;
          ST_B2:   b_2_r <= s_out_s;
          default: ;
        endcase
      end
    end
  end

  // Last byte bypasses the registers straight onto rd so the result is ready in state 3.
  always_comb begin
    ready = (fsm_r == ST_B3) && valid;
    rd    = {s_out_s, b_2_r, b_1_r, b_0_r};
  end

endmodule

// File: tb/tb_aes_v2_sub_size.sv
// tb_aes_v2_sub_size: self-checking bench for aes_v2_sub_size with an
// independently generated S-box reference and an expected-result queue.
module tb_aes_v2_sub_size;

  logic        g_clk;
  logic        g_reset;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        ready;
  logic [31:0] rd;

  int n_chk;
  int n_pass;

  logic [7:0]  fwd_tbl [256];
  logic [7:0]  inv_tbl [256];
  logic [31:0] sb_q [$];

  aes_v2_sub_size dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .valid   (valid),
    .rs1     (rs1),
    .rs2     (rs2),
    .enc     (enc),
    .ready   (ready),
    .rd      (rd)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Reference tables from the 3-generator walk (p *= 3, q /= 3).
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      fwd_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_tbl[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = i[7:0];
  endtask

  function automatic logic [7:0] ref_s(input logic [7:0] b, input logic e);
    return e ? fwd_tbl[b] : inv_tbl[b];
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] r1, input logic [31:0] r2, input logic e);
    return {ref_s(r2[31:24], e), ref_s(r2[23:16], e), ref_s(r1[15:8], e), ref_s(r1[7:0], e)};
  endfunction

  // One full instruction; entered and left at posedge+1 with valid left high.
  task automatic run_op(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                        input logic e, input logic [31:0] exp);
    logic [31:0] want;
    sb_q.push_back(exp);
    valid = 1'b1;
    rs1   = r1;
    rs2   = r2;
    enc   = e;
    for (int c = 0; c < 4; c++) begin
      @(negedge g_clk);
      if (c < 3) begin
        chk({tag, "_early_ready"}, {31'd0, ready}, 32'd0);
      end else begin
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        if (ready && sb_q.size() > 0) begin
          want = sb_q.pop_front();
          chk({tag, "_rd"}, rd, want);
        end
      end
      @(posedge g_clk);
      #1;
    end
  endtask

  task automatic idle_cycle(input string tag);
    valid = 1'b0;
    @(negedge g_clk);
    chk({tag, "_idle_ready"}, {31'd0, ready}, 32'd0);
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    g_reset = 1'b1;
    valid   = 1'b0;
    rs1     = 32'h0000_0153;
    rs2     = 32'hFF00_1234;
    enc     = 1'b1;
    build_tables();

    // Reset state: ready low, byte registers clear, top byte from S-box of byte 0.
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rd", rd, {8'hED, 24'h0});
    @(negedge g_clk);
    g_reset = 1'b0;
    @(posedge g_clk);
    #1;

    run_op("enc", 32'h0000_0153, 32'hFF00_1234, 1'b1, 32'h1663_7CED);
    idle_cycle("enc");
    run_op("dec", 32'hAAAA_63ED, 32'h167C_5555, 1'b0, 32'hFF01_0053);
    idle_cycle("dec");

    // Abort after two cycles, then restart.
    valid = 1'b1;
    rs1   = 32'h0000_0153;
    rs2   = 32'hFF00_1234;
    enc   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge g_clk);
      chk("abort_ready", {31'd0, ready}, 32'd0);
      @(posedge g_clk);
      #1;
    end
    idle_cycle("abort");
    run_op("restart", 32'h0000_0153, 32'hFF00_1234, 1'b1, 32'h1663_7CED);

    // Back-to-back, valid held high across the boundary.
    run_op("b2b_a", 32'h0000_0153, 32'hFF00_1234, 1'b1, 32'h1663_7CED);
    run_op("b2b_b", 32'hAAAA_63ED, 32'h167C_5555, 1'b0, 32'hFF01_0053);
    idle_cycle("b2b");

    // Reset asserted between edges in state 2.
    valid = 1'b1;
    rs1   = 32'h1234_5678;
    rs2   = 32'h9ABC_DEF0;
    enc   = 1'b1;
    @(posedge g_clk);
    @(posedge g_clk);
    #2;
    g_reset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_rd", rd, {fwd_tbl[8'h78], 24'h0});
    valid = 1'b0;
    @(negedge g_clk);
    g_reset = 1'b0;
    @(posedge g_clk);
    #1;
    run_op("post_rst", 32'h0000_0153, 32'hFF00_1234, 1'b1, 32'h1663_7CED);

    // Exhaustive: every byte value in every lane, junk in unused bytes.
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 256; x++) begin
        logic [7:0]  l0, l1, l2, l3;
        logic [31:0] r1, r2;
        logic        e;
        e  = (m == 0);
        l0 = x[7:0];
        l1 = x[7:0] + 8'd64;
        l2 = x[7:0] + 8'd128;
        l3 = x[7:0] + 8'd192;
        r1 = {$urandom_range(0, 65535), l1, l0};
        r1[31:16] = $urandom_range(0, 65535);
        r2 = {l3, l2, 16'h0};
        r2[15:0] = $urandom_range(0, 65535);
        run_op(e ? "sweep_fwd" : "sweep_inv", r1, r2, e, ref_rd(r1, r2, e));
      end
    end

    // Inverse of forward returns the original byte in every lane.
    for (int x = 0; x < 256; x += 5) begin
      logic [7:0]  v;
      logic [31:0] r1, r2;
      v  = x[7:0];
      r1 = {16'hDEAD, fwd_tbl[v ^ 8'h5A], fwd_tbl[v]};
      r2 = {fwd_tbl[~v], fwd_tbl[v + 8'd1], 16'hBEEF};
      run_op("roundtrip", r1, r2, 1'b0, {~v, v + 8'd1, v ^ 8'h5A, v});
    end
    idle_cycle("end");

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
